// File: rtl/exu_lsu_pkg.sv
// Shared encodings for the execute-stage load/store unit: access sizes, LSU states
// and the default idle memory address.
package exu_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    localparam logic [63:0] LSU_BASE_ADDR = 64'h0000_0000_8000_0000;

    // A doubleword access on a 32-bit datapath degrades to a word access.
    function automatic logic [1:0] lsu_eff_size(input logic [1:0] size, input int unsigned xlen);
        return (xlen == 32 && size == SIZE_D) ? SIZE_W : size;
    endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// Byte-lane helper: store data shift and strobes, load extract and sign/zero extension.
// With LSU_MISALIGN_CHECK_EN undefined the lane offset is rounded down to natural alignment.
module exu_lsu_align
    import exu_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]                 size,
    input  logic                       is_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN-1:0]            wdata_sh,
    output logic [XLEN/8-1:0]          wstrb,
    output logic [XLEN-1:0]            rdata_ext,
    output logic                       misaligned
);

    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(XLEN);

    logic [1:0]        eff_size;
    int unsigned       nbytes;
    logic [OFF_W-1:0]  size_mask;
    logic [OFF_W-1:0]  a_off;
    logic [XLEN-1:0]   rsh;
    logic [XLEN-1:0]   keep_mask;
    logic [IDX_W-1:0]  msb_idx;
    logic              sign_bit;

    always_comb begin
        eff_size   = lsu_eff_size(size, XLEN);
        nbytes     = 32'd1 << eff_size;
        size_mask  = OFF_W'(nbytes - 1);
        misaligned = (off & size_mask) != '0;
`ifdef LSU_MISALIGN_CHECK_EN
        a_off      = off;
`else
        a_off      = off & ~size_mask;
`endif
        wstrb      = ~({STRB_W{1'b1}} << nbytes) << a_off;
        wdata_sh   = wdata << {a_off, 3'b000};

        // Shifting all-ones by the full width yields zero, so a full-width load keeps every bit.
        rsh        = rdata >> {a_off, 3'b000};
        keep_mask  = ~({XLEN{1'b1}} << (8 * nbytes));
        msb_idx    = IDX_W'(8 * nbytes - 1);
        sign_bit   = rsh[msb_idx] & ~is_unsigned;
        rdata_ext  = (rsh & keep_mask) | (sign_bit ? ~keep_mask : '0);
    end

endmodule

// File: rtl/exu_lsu.sv
// Multi-cycle load/store unit: one outstanding access, registered memory and response ports.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned accesses instead of force-aligning them.
module exu_lsu
    import exu_lsu_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(LSU_BASE_ADDR),
    parameter int unsigned     STRB_W    = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned OFF_W = $clog2(STRB_W);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [XLEN-1:0]   st_wdata_sh, st_rdata_ext, ld_wdata_sh, ld_rdata_ext;
    logic [STRB_W-1:0] st_wstrb, ld_wstrb;
    logic              st_misaligned, ld_misaligned;
    logic              req_err;
    logic              unused_align;

    exu_lsu_align #(.XLEN(XLEN)) u_align_st (
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .off         (req_addr[OFF_W-1:0]),
        .wdata       (req_wdata),
        .rdata       ('0),
        .wdata_sh    (st_wdata_sh),
        .wstrb       (st_wstrb),
        .rdata_ext   (st_rdata_ext),
        .misaligned  (st_misaligned)
    );

    exu_lsu_align #(.XLEN(XLEN)) u_align_ld (
        .size        (size_q),
        .is_unsigned (uns_q),
        .off         (off_q),
        .wdata       ('0),
        .rdata       (mem_rdata),
        .wdata_sh    (ld_wdata_sh),
        .wstrb       (ld_wstrb),
        .rdata_ext   (ld_rdata_ext),
        .misaligned  (ld_misaligned)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign req_err      = st_misaligned;
    assign unused_align = ^{st_rdata_ext, ld_wdata_sh, ld_wstrb, ld_misaligned};
`else
    assign req_err      = 1'b0;
    assign unused_align = ^{st_rdata_ext, ld_wdata_sh, ld_wstrb, ld_misaligned, st_misaligned};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= LSU_IDLE;
            size_q          <= '0;
            uns_q           <= 1'b0;
            off_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= BASE_ADDR;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wstrb_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            off_q           <= off_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (req_valid)     state_d = req_err ? LSU_DONE : LSU_REQ;
            LSU_REQ:  if (mem_req_ready) state_d = mem_we_q ? LSU_DONE : LSU_WAIT;
            LSU_WAIT: if (mem_rsp_valid) state_d = LSU_DONE;
            LSU_DONE: if (rsp_ready)     state_d = LSU_IDLE;
            default:                     state_d = LSU_IDLE;
        endcase
    end

    // Memory-side outputs are loaded on accept and returned to idle values on handshake,
    // so every mem_* and rsp_* port comes straight from a flop.
    always_comb begin
        req_ready       = (state_q == LSU_IDLE);
        size_d          = size_q;
        uns_d           = uns_q;
        off_d           = off_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = mem_we_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wstrb_d     = mem_wstrb_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_err_d       = rsp_err_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[OFF_W-1:0];
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                        mem_we_d        = req_we;
                        mem_wdata_d     = st_wdata_sh;
                        mem_wstrb_d     = st_wstrb;
                    end
                end
            end
            LSU_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    mem_addr_d      = BASE_ADDR;
                    mem_we_d        = 1'b0;
                    mem_wdata_d     = '0;
                    mem_wstrb_d     = '0;
                    if (mem_we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            LSU_WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_rdata_ext;
                    rsp_err_d   = 1'b0;
                end
            end
            LSU_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_exu_lsu.sv
// Self-checking bench for exu_lsu (XLEN=32) against a byte-lane arithmetic reference model.
// Expectations follow LSU_MISALIGN_CHECK_EN when the build defines it.
module tb_exu_lsu;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct packed {
        logic        seen_mem;
        logic [7:0]  mem_cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        seen_rsp;
        logic [7:0]  rsp_cyc;
        logic [31:0] rdata;
        logic        err;
        logic        stable;
        logic        busy_ok;
        logic        idle_ok;
        logic        end_ok;
        logic        timeout;
    } obs_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] l_addr;
        logic [3:0]  l_wstrb;
        logic [31:0] l_wdata;
        logic [31:0] l_rdata;
    } dir_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready;
    logic        mem_req_valid, mem_we;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_lsu #(.XLEN(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Reference: what one access should look like at the ports, from the lane rules.
    function automatic obs_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input int unsigned md);
        obs_t e;
        int unsigned s, nb, off;
        longint unsigned v, m;
        e = '0;
        e.stable = 1'b1; e.busy_ok = 1'b1; e.idle_ok = 1'b1; e.end_ok = 1'b1;
        s   = (sz == 2'd3) ? 2 : int'(sz);
        nb  = 1 << s;
        off = addr % 4;
`ifdef LSU_MISALIGN_CHECK_EN
        if (off % nb != 0) begin
            e.seen_rsp = 1'b1; e.rsp_cyc = 8'd1; e.err = 1'b1;
            return e;
        end
`endif
        off = off - (off % nb);
        e.seen_mem = 1'b1;
        e.mem_cyc  = 8'd1;
        e.addr     = addr - (addr % 4);
        e.we       = we;
        e.wdata    = 32'(64'(wdata) << (8 * off));
        e.wstrb    = 4'(((32'd1 << nb) - 1) << off);
        e.seen_rsp = 1'b1;
        e.rsp_cyc  = 8'((we ? 2 : 3) + md);
        if (!we) begin
            m = (64'd1 << (8 * nb)) - 1;
            v = (64'(rdata) >> (8 * off)) & m;
            if (!uns && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~m;
            e.rdata = 32'(v);
        end
        return e;
    endfunction

    // Runs one access end to end, recording what the ports did; cycle 1 is the cycle after accept.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int unsigned md,
                             input int unsigned rd, output obs_t ob);
        int unsigned cyc, mcnt, rcnt;
        logic give_rsp, hs, rhs, done;
        ob = '0;
        ob.stable = 1'b1; ob.busy_ok = 1'b1; ob.idle_ok = 1'b1;
        give_rsp = 1'b0; done = 1'b0; mcnt = 0; rcnt = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        cyc = 1;
        while (!done && cyc < 60) begin
            hs = 1'b0; rhs = 1'b0;
            if (req_ready !== 1'b0) ob.busy_ok = 1'b0;
            if (mem_req_valid === 1'b1) begin
                if (!ob.seen_mem) begin
                    ob.seen_mem = 1'b1; ob.mem_cyc = 8'(cyc);
                    ob.addr = mem_addr; ob.we = mem_we; ob.wdata = mem_wdata; ob.wstrb = mem_wstrb;
                end else if ({mem_addr, mem_we, mem_wdata, mem_wstrb} !== {ob.addr, ob.we, ob.wdata, ob.wstrb})
                    ob.stable = 1'b0;
                hs = (mcnt >= md);
                mcnt++;
            end else if ({mem_addr, mem_we, mem_wdata, mem_wstrb} !== {BASE, 1'b0, 32'h0, 4'h0})
                ob.idle_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                if (!ob.seen_rsp) begin
                    ob.seen_rsp = 1'b1; ob.rsp_cyc = 8'(cyc); ob.rdata = rsp_rdata; ob.err = rsp_err;
                end else if ({rsp_rdata, rsp_err} !== {ob.rdata, ob.err})
                    ob.stable = 1'b0;
                rhs = (rcnt >= rd);
                rcnt++;
            end
            mem_req_ready = hs;
            rsp_ready     = rhs;
            // Stray responses while stalled in REQ or DONE must be ignored by the LSU.
            mem_rsp_valid = give_rsp | (mem_req_valid & ~hs) | (rsp_valid & ~rhs);
            mem_rdata     = give_rsp ? rdata : $urandom;
            @(posedge clk); #1;
            give_rsp = hs & ~we;
            done     = rhs;
            cyc++;
        end
        mem_req_ready = 1'b0; rsp_ready = 1'b0; mem_rsp_valid = 1'b0;
        ob.timeout = !done;
        ob.end_ok  = (req_ready === 1'b1) && (rsp_valid === 1'b0) && (mem_req_valid === 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++;
        if ({mem_req_valid, mem_we, mem_wstrb} !== 6'b0) begin
            errors++; $display("FAIL reset_mem_ctrl: got %b want 000000", {mem_req_valid, mem_we, mem_wstrb});
        end
        checks++;
        if (mem_addr !== BASE) begin errors++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, BASE); end
        checks++;
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want all 0", rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, mem_req_valid, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL post_reset_idle: got %b want 100", {req_ready, mem_req_valid, rsp_valid});
        end
    endtask

    task automatic test_directed;
        dir_t tbl[7];
        obs_t ob, ex;
        tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,
                   32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        tbl[1] = '{1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_1234, 32'h0,
                   32'h8000_0000, 4'b1100, 32'h1234_0000, 32'h0};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_FF00,
                   32'h8000_0000, 4'b1000, 32'h0, 32'hFFFF_FF80};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_FF00,
                   32'h8000_0000, 4'b1000, 32'h0, 32'h0000_0080};
        tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_7F00,
                   32'h8000_0000, 4'b1100, 32'h0, 32'hFFFF_8001};
        tbl[5] = '{1'b0, 2'd3, 1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_BABE,
                   32'h8000_0008, 4'b1111, 32'h0, 32'hCAFE_BABE};
        tbl[6] = '{1'b1, 2'd0, 1'b0, 32'h8000_0005, 32'h0000_00A5, 32'h0,
                   32'h8000_0004, 4'b0010, 32'h0000_A500, 32'h0};
        for (int i = 0; i < 7; i++) begin
            do_access(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, 0, 0, ob);
            ex = model(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, 0);
            checks++;
            if (ob !== ex) begin
                errors++; $display("FAIL directed_%0d: got %p want %p", i, ob, ex);
            end
            checks++;
            if ({ob.addr, ob.wstrb, ob.wdata, ob.rdata} !== {tbl[i].l_addr, tbl[i].l_wstrb, tbl[i].l_wdata, tbl[i].l_rdata}) begin
                errors++;
                $display("FAIL directed_lanes_%0d: got addr=%h strb=%b wd=%h rd=%h want addr=%h strb=%b wd=%h rd=%h",
                         i, ob.addr, ob.wstrb, ob.wdata, ob.rdata,
                         tbl[i].l_addr, tbl[i].l_wstrb, tbl[i].l_wdata, tbl[i].l_rdata);
            end
        end
    endtask

    task automatic test_misaligned;
        obs_t ob, ex;
        do_access(1'b1, 2'd2, 1'b0, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0, 0, 0, ob);
        ex = model(1'b1, 2'd2, 1'b0, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0, 0);
        checks++;
        if (ob !== ex) begin errors++; $display("FAIL misaligned_store: got %p want %p", ob, ex); end
        checks++;
`ifdef LSU_MISALIGN_CHECK_EN
        if ({ob.seen_mem, ob.err, ob.rsp_cyc, ob.rdata} !== {1'b0, 1'b1, 8'd1, 32'h0}) begin
            errors++; $display("FAIL misaligned_err: got mem=%b err=%b cyc=%0d rd=%h want mem=0 err=1 cyc=1 rd=0",
                               ob.seen_mem, ob.err, ob.rsp_cyc, ob.rdata);
        end
`else
        if ({ob.addr, ob.wstrb, ob.err} !== {32'h8000_0000, 4'b1111, 1'b0}) begin
            errors++; $display("FAIL misaligned_forced: got addr=%h strb=%b err=%b want 80000000 1111 0",
                               ob.addr, ob.wstrb, ob.err);
        end
`endif
        do_access(1'b0, 2'd1, 1'b0, 32'h8000_0003, 32'h0, 32'h1234_5678, 0, 0, ob);
        ex = model(1'b0, 2'd1, 1'b0, 32'h8000_0003, 32'h0, 32'h1234_5678, 0);
        checks++;
        if (ob !== ex) begin errors++; $display("FAIL misaligned_load: got %p want %p", ob, ex); end
    endtask

    task automatic test_back_pressure;
        obs_t ob, ex;
        do_access(1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h0000_BEEF, 32'h0, 3, 2, ob);
        ex = model(1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h0000_BEEF, 32'h0, 3);
        checks++;
        if (ob !== ex) begin errors++; $display("FAIL backpressure_store: got %p want %p", ob, ex); end
        do_access(1'b0, 2'd0, 1'b0, 32'h8000_0021, 32'h0, 32'h1234_F600, 3, 2, ob);
        ex = model(1'b0, 2'd0, 1'b0, 32'h8000_0021, 32'h0, 32'h1234_F600, 3);
        checks++;
        if (ob !== ex) begin errors++; $display("FAIL backpressure_load: got %p want %p", ob, ex); end
    endtask

    task automatic test_random;
        obs_t ob, ex;
        logic we, uns;
        logic [1:0] sz;
        logic [31:0] addr, wd, rd;
        int unsigned md, rdl;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
            addr = BASE | ($urandom & 32'h0000_FFFF);
            wd = $urandom; rd = $urandom;
            md = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
            do_access(we, sz, uns, addr, wd, rd, md, rdl, ob);
            ex = model(we, sz, uns, addr, wd, rd, md);
            checks++;
            if (ob !== ex) begin
                errors++; $display("FAIL random_%0d we=%b sz=%0d uns=%b addr=%h: got %p want %p",
                                   i, we, sz, uns, addr, ob, ex);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8000_0010; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        checks++;
        if ({req_ready, mem_req_valid, rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL wait_state: got %b want 000", {req_ready, mem_req_valid, rsp_valid});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, mem_req_valid, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL async_reset: got %b want 100", {req_ready, mem_req_valid, rsp_valid});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({req_ready, rsp_valid, mem_req_valid} !== 3'b100) begin
                errors++; $display("FAIL late_rsp_%0d: got %b want 100", i, {req_ready, rsp_valid, mem_req_valid});
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_back_pressure();
        test_random();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_lsu.md
# exu_lsu

Multi-cycle load/store unit for the NPC execute stage: the next generation of the combinational memory-control path. It takes one load or store per request from the EXU, drives a valid/ready memory port with byte strobes, and returns sign- or zero-extended load data through a held response handshake. It sits between the EXU (address from `alu_result`, store data from `src2`) and the data memory or bus bridge. There is one outstanding access at a time.

## Interface
- `XLEN`, default 32: data width; 32 or 64 only.
- `BASE_ADDR`, default 32'h8000_0000: value driven on `mem_addr` when no request is valid.
- `STRB_W`, default XLEN/8 (derived; do not override): byte lanes.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: EXU presents an access.
- `req_ready` out 1: LSU can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN=64).
- `req_unsigned` in 1: zero-extend the load (lbu/lhu/lwu); ignored for stores.
- `req_addr` in XLEN: byte address (`alu_result`).
- `req_wdata` in XLEN: store data, LSB-aligned (`src2`).
- `mem_req_valid` out 1; `mem_req_ready` in 1: memory request handshake.
- `mem_addr` out XLEN: address aligned to STRB_W.
- `mem_we` out 1; `mem_wdata` out XLEN; `mem_wstrb` out STRB_W: lane-shifted data and strobes.
- `mem_rsp_valid` in 1; `mem_rdata` in XLEN: load response; no back-pressure.
- `rsp_valid` out 1; `rsp_ready` in 1: result handshake to WBU.
- `rsp_rdata` out XLEN: extended load data; 0 for stores.
- `rsp_err` out 1: misaligned access (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `req_ready` = 1. On `req_valid`, register we, size, unsigned, addr, wdata, and computed strobes/data. Go to REQ, or to DONE with error when misaligned (checking enabled).
- REQ: `mem_req_valid` = 1, outputs stable until `mem_req_ready`. On handshake, a store goes to DONE and a load goes to WAIT.
- WAIT: on `mem_rsp_valid`, capture and extend the data, then go to DONE. A `mem_rsp_valid` seen in any other state is ignored.
- DONE: `rsp_valid` = 1, held with stable data until `rsp_ready`, then IDLE.
- Lane arithmetic:
  - off = addr[log2(STRB_W)-1:0]; mem_addr = {addr[XLEN-1:log2(STRB_W)], 0}.
  - mem_wdata = wdata << (8·off).
  - mem_wstrb = ((1 << 2^size) − 1) << off, truncated to STRB_W.
  - Load: shift `mem_rdata` right by 8·off, take 8·2^size bits, then sign- or zero-extend to XLEN.
- Size 3 with XLEN=32 is illegal. It is treated as size 2.
- `mem_addr` = BASE_ADDR and `mem_wdata`/`mem_wstrb`/`mem_we` = 0 whenever `mem_req_valid` = 0.

## Timing
- Reset values: state IDLE, `req_ready` 1, `mem_req_valid` 0, `mem_addr` BASE_ADDR, `mem_we` 0, `mem_wdata` 0, `mem_wstrb` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0.
- Best-case store:
  - Accept at cycle 0.
  - `mem_req_valid` at cycle 1; with `mem_req_ready` = 1, the handshake completes at cycle 1.
  - `rsp_valid` at cycle 2.
- Best-case load:
  - Same as the store through cycle 1.
  - `mem_rsp_valid` at cycle 2.
  - `rsp_valid` at cycle 3.
- Misaligned access with checking enabled: `rsp_valid` at cycle 1 and no memory request.
- No combinational path from `req_*` to `mem_*`, or from `mem_*` to `rsp_*`. All `mem_*` and `rsp_*` outputs are registers.
- Reset asserted mid-access: return to IDLE immediately and drop every valid. A memory response arriving after reset is ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - A misaligned access (off not a multiple of 2^size) issues no memory request.
  - The LSU goes IDLE→DONE with `rsp_err` = 1 and `rsp_rdata` = 0.
- Not defined:
  - `rsp_err` is tied to 0.
  - off is forced down to a multiple of 2^size before the lane computation, so the access becomes naturally aligned.

## Structure
- The shared header (alongside config.vh/inst.vh) holds:
  - the size encodings `SIZE_B/H/W/D`;
  - the state encodings `LSU_IDLE/REQ/WAIT/DONE`;
  - the `BASE_ADDR` default.
- One combinational sub-module, `exu_lsu_align`, computes the store shift/strobe and the load extract/extend. It is instantiated twice: once on the store path and once on the load path.

## Test plan
- Store word, addr 0x8000_0004, wdata 0xDEAD_BEEF, XLEN=32 -> mem_addr 0x8000_0004, wstrb 4'b1111, wdata 0xDEAD_BEEF; `rsp_valid` at cycle 2.
- Store half, addr 0x8000_0002, wdata 0x0000_1234 -> wstrb 4'b1100, mem_wdata 0x1234_0000, mem_addr 0x8000_0000.
- Load byte signed/unsigned, addr 0x8000_0003, mem_rdata 0x80FF_FF00 -> rsp_rdata 0xFFFF_FF80 (signed) and 0x0000_0080 (unsigned).
- Back-pressure: `mem_req_ready` held low 3 cycles and `rsp_ready` held low 2 cycles -> mem outputs and `rsp_rdata` stable throughout, `req_ready` 0 throughout.
- Misaligned word at 0x8000_0001 with `LSU_MISALIGN_CHECK_EN` defined -> no `mem_req_valid`, `rsp_err` 1 at cycle 1. Same access with the macro undefined -> mem_addr 0x8000_0000, wstrb 4'b1111.
- `rst` driven low while in WAIT, then a late `mem_rsp_valid` -> IDLE, `rsp_valid` stays 0, `req_ready` 1.
